mcpu_gen: RTL
=============

MCPU_GEN -- requirements
Module: mcpu_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, address width (legal range 4..14).
REQ-002 SHALL have parameter HALT_DETECT, default 1, enables self-jump halt detection.
REQ-003 SHALL derive localparam DATA_W = ADDR_W+2; instruction word = {opcode[1:0], addr[ADDR_W-1:0]}.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 datain  input  DATA_W  memory read data.
REQ-007 dataout  output  DATA_W  memory write data, equals accumulator at all times.
REQ-008 adress  output  ADDR_W  memory address.
REQ-009 oe  output  1  memory read enable.
REQ-010 we  output  1  memory write enable.
REQ-011 mem_ready  input  1  memory handshake; access completes on a clock edge with mem_ready=1.
REQ-012 halt  output  1  high while CPU is halted.

Function
REQ-013 SHALL hold registers pc[ADDR_W], acc[DATA_W], carry, ir[DATA_W], state.
REQ-014 SHALL implement states FETCH, DECODE, READ, WRITE, HALT; outputs are decoded from state and registers (no added output latency).
REQ-015 FETCH: adress=pc, oe=1, we=0; on mem_ready=1: ir<=datain, pc<=pc+1 mod 2^ADDR_W, ->DECODE; else hold with all outputs stable.
REQ-016 DECODE: oe=0, we=0, adress=ir addr field; opcode 00 (NOR) or 01 (ADD) ->READ; 10 (STA) ->WRITE; 11 (JCC) resolved here.
REQ-017 JCC, carry=1: carry<=0, pc unchanged, ->FETCH.
REQ-018 JCC, carry=0: pc<=ir addr; if HALT_DETECT=1 and ir addr == pc-1 mod 2^ADDR_W (self-jump) ->HALT, else ->FETCH.
REQ-019 READ: adress=ir addr, oe=1, we=0; on mem_ready=1: NOR: acc<=~(acc|datain), carry unchanged; ADD: {carry,acc}<=acc+datain as DATA_W+1-bit sum; ->FETCH.
REQ-020 WRITE: adress=ir addr, oe=0, we=1, dataout=acc; on mem_ready=1 ->FETCH; we held while mem_ready=0.
REQ-021 HALT: oe=0, we=0, halt=1, adress=pc; stays until rst; halt=0 in all other states.
REQ-022 oe and we SHALL never be high simultaneously.
REQ-023 With mem_ready tied 1: NOR/ADD/STA take 3 cycles, JCC takes 2 cycles.
REQ-024 pc increment and ADD SHALL wrap silently (2^ADDR_W-1 -> 0; carry captures ADD overflow only).

Reset
REQ-025 While rst=1: state=FETCH, pc=0, acc=0, carry=0, ir=0, so adress=0, oe=1, we=0, dataout=0, halt=0.
REQ-026 rst assertion SHALL take effect immediately without a clock edge, including mid-READ/WRITE/HALT (we drops combinationally).
REQ-027 After rst deasserts, first fetch from address 0 completes on first edge with mem_ready=1.

Verification (ADDR_W=6, DATA_W=8, mem_ready=1 unless stated)
REQ-028 Reset: rst=1, any state -> adress=0x00, oe=1, we=0, halt=0, dataout=0x00.
REQ-029 Program 0x3F,0x7E,0xBD with mem[3F]=0xFE, mem[3E]=0xFF -> acc=0x01 after NOR, acc=0x00 carry=1 after ADD, write 0x00 to 0x3D with we=1 for one cycle; total 9 cycles.
REQ-030 JCC 0x20 (0xE0) with carry=1 -> pc falls through, carry=0; repeat with carry=0 -> next fetch adress=0x20.
REQ-031 Halt: 0xC5 at address 0x05, carry=0 -> halt=1, oe=0, we=0 from cycle after DECODE, held 20 cycles; with HALT_DETECT=0 -> refetch of 0x05 instead.
REQ-032 Wait states: mem_ready=0 for 3 cycles in FETCH and in WRITE -> adress, oe/we, pc, acc stable; completion on 4th edge.
REQ-033 rst pulsed mid-WRITE between edges -> we=0 and adress=0 before next clock edge; execution restarts at address 0.

Source files
------------

// File: rtl/mcpu_gen.sv
// Minimal accumulator CPU: NOR / ADD / STA / JCC over a ready-handshaked memory bus.
// Bus outputs are decoded directly from the current state and registers.
module mcpu_gen #(
  parameter int ADDR_W      = 6,
  parameter int HALT_DETECT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W+1:0] datain,
  output logic [ADDR_W+1:0] dataout,
  output logic [ADDR_W-1:0] adress,
  output logic              oe,
  output logic              we,
  input  logic              mem_ready,
  output logic              halt
);
  localparam int DATA_W = ADDR_W + 2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_READ   = 3'd2,
    S_WRITE  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                carry_q, carry_d;

  logic [1:0]          op;
  logic [ADDR_W-1:0]   ir_addr;
  logic [ADDR_W-1:0]   pc_prev;
  logic [DATA_W:0]     sum;

  assign op      = ir_q[DATA_W-1 -: 2];
  assign ir_addr = ir_q[ADDR_W-1:0];
  // pc already points past the JCC, so a self-jump targets pc-1
  assign pc_prev = pc_q - ADDR_W'(1);
  assign sum     = {1'b0, acc_q} + {1'b0, datain};
  assign dataout = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      acc_q   <= '0;
      ir_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = datain;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          2'b00, 2'b01: state_d = S_READ;
          2'b10:        state_d = S_WRITE;
          default: begin
            if (carry_q) begin
              carry_d = 1'b0;
              state_d = S_FETCH;
            end else begin
              pc_d    = ir_addr;
              state_d = (HALT_DETECT != 0 && ir_addr == pc_prev) ? S_HALT : S_FETCH;
            end
          end
        endcase
      end
      S_READ: begin
        if (mem_ready) begin
          if (op[0]) {carry_d, acc_d} = sum;
          else       acc_d = ~(acc_q | datain);
          state_d = S_FETCH;
        end
      end
      S_WRITE: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    adress = pc_q;
    oe     = 1'b0;
    we     = 1'b0;
    halt   = 1'b0;
    case (state_q)
      S_FETCH:  oe = 1'b1;
      S_DECODE: adress = ir_addr;
      S_READ: begin
        adress = ir_addr;
        oe     = 1'b1;
      end
      S_WRITE: begin
        adress = ir_addr;
        we     = 1'b1;
      end
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end
endmodule
